// File: rtl/loader_pkg.sv
// loader_pkg: shared types and frame constants for the instruction-memory loader
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam int LEN_BYTES = 2;
    localparam int CK_BYTES  = 1;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: boot loader turning a framed byte stream into instruction-memory writes
// Ports:
//   clk, rst (async active-low)
//   start                     begin a load (taken only in IDLE/DONE/ERROR)
//   in_data/in_valid/in_ready byte stream handshake
//   mem_waddr/mem_wdata/mem_we registered instruction-memory write port
//   cpu_run                   CPU reset release, set only after a verified load
//   busy/done/error           status: load in progress, success pulse, failure level
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mem_waddr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        cpu_run,
    output logic        busy,
    output logic        done,
    output logic        error
);

    loader_state_t   state;
    logic [7:0]      hi;
    logic [7:0]      acc;
    logic [ADDR_W:0] idx;
    logic [16:0]     len;
    logic [16:0]     n_val;

    // hi holds LEN_HI first, then each word's high byte
    assign n_val    = {1'b0, hi, in_data};
    assign in_ready = state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK};
    assign busy     = in_ready;
    assign error    = state == ST_ERROR;

    // in_ready is high in every consuming state, so in_valid alone marks a transfer there
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            hi        <= '0;
            acc       <= '0;
            idx       <= '0;
            len       <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cpu_run   <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: if (start) begin
                    state   <= ST_LEN_HI;
                    idx     <= '0;
                    acc     <= '0;
                    cpu_run <= 1'b0;
                end
                ST_LEN_HI: if (in_valid) begin
                    hi    <= in_data;
                    state <= ST_LEN_LO;
                end
                ST_LEN_LO: if (in_valid) begin
                    len   <= n_val;
                    state <= n_val > (17'd1 << ADDR_W) ? ST_ERROR :
                             n_val == 17'd0            ? ST_CHECK : ST_DATA_HI;
                end
                ST_DATA_HI: if (in_valid) begin
                    hi    <= in_data;
                    acc   <= acc ^ in_data;
                    state <= ST_DATA_LO;
                end
                ST_DATA_LO: if (in_valid) begin
                    mem_we    <= 1'b1;
                    mem_waddr <= 16'(idx[ADDR_W-1:0]);
                    mem_wdata <= {hi, in_data};
                    acc       <= acc ^ in_data;
                    idx       <= idx + 1'b1;
                    state     <= 17'(idx) + 17'd1 == len ? ST_CHECK : ST_DATA_HI;
                end
                ST_CHECK: if (in_valid) begin
                    if (in_data == acc) begin
                        state   <= ST_DONE;
                        cpu_run <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        state <= ST_ERROR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_run;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int cyc = 0;
    logic [15:0] wa[$];
    logic [15:0] wd[$];
    logic [15:0] img[3];

    imem_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .cpu_run(cpu_run), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_waddr);
            wd.push_back(mem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // presents one byte after gap idle cycles, returns 1ns after the accepting edge
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) idle(gap);
        in_data = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        total++;
        if (t >= 50) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic int gap_of(input int maxgap);
        return maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0;
    endfunction

    task automatic send_frame(input logic [15:0] n, input int nw, input logic [7:0] ck, input int maxgap);
        send(n[15:8], gap_of(maxgap));
        send(n[7:0], gap_of(maxgap));
        for (int i = 0; i < nw; i++) begin
            send(img[i][15:8], gap_of(maxgap));
            send(img[i][7:0], gap_of(maxgap));
            total++;
            if (mem_we !== 1'b1 || mem_waddr !== 16'(i) || mem_wdata !== img[i]) begin
                bad++;
                $display("FAIL write_latency[%0d]: we=%0b addr=%h data=%h required we=1 addr=%h data=%h",
                         i, mem_we, mem_waddr, mem_wdata, 16'(i), img[i]);
            end
        end
        send(ck, gap_of(maxgap));
    endtask

    task automatic check_writes(input string name, input int nw);
        total++;
        if (wa.size() != nw) begin
            bad++;
            $display("FAIL %s_count: writes=%0d required=%0d", name, wa.size(), nw);
        end else begin
            for (int i = 0; i < nw; i++) begin
                total++;
                if (wa[i] !== 16'(i) || wd[i] !== img[i]) begin
                    bad++;
                    $display("FAIL %s_word[%0d]: addr=%h data=%h required addr=%h data=%h",
                             name, i, wa[i], wd[i], 16'(i), img[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if ({in_ready, mem_we, mem_waddr, mem_wdata, cpu_run, busy, done, error} !== 38'd0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%0b we=%0b addr=%h data=%h run=%0b busy=%0b done=%0b err=%0b required all 0",
                     in_ready, mem_we, mem_waddr, mem_wdata, cpu_run, busy, done, error);
        end
    endtask

    task automatic test_good_load();
        int c0;
        img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h00FF;
        clear_log();
        pulse_start();
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_ready: rdy=%0b busy=%0b required 1 1", in_ready, busy);
        end
        c0 = cyc;
        send_frame(16'd3, 3, 8'hBF, 0);
        total++;
        if (cyc - c0 != 9) begin
            bad++;
            $display("FAIL back_to_back: cycles=%0d required=9", cyc - c0);
        end
        total++;
        if (done !== 1'b1 || cpu_run !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL good_done: done=%0b run=%0b busy=%0b rdy=%0b required 1 1 0 0", done, cpu_run, busy, in_ready);
        end
        idle(3);
        check_writes("good", 3);
        total++;
        if (done_cnt != 1 || cpu_run !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL good_sticky: pulses=%0d run=%0b err=%0b required 1 1 0", done_cnt, cpu_run, error);
        end
    endtask

    task automatic test_bad_checksum();
        img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h00FF;
        clear_log();
        pulse_start();
        total++;
        if (cpu_run !== 1'b0) begin
            bad++;
            $display("FAIL start_clears_run: run=%0b required=0", cpu_run);
        end
        send_frame(16'd3, 3, 8'hBE, 0);
        idle(3);
        check_writes("bad_ck", 3);
        total++;
        if (error !== 1'b1 || cpu_run !== 1'b0 || done_cnt != 0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bad_ck_state: err=%0b run=%0b pulses=%0d rdy=%0b required 1 0 0 0", error, cpu_run, done_cnt, in_ready);
        end
        clear_log();
        pulse_start();
        total++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL error_restart: err=%0b rdy=%0b required 0 1", error, in_ready);
        end
        send_frame(16'd3, 3, 8'hBF, 0);
        idle(2);
        check_writes("retry", 3);
        total++;
        if (done_cnt != 1 || cpu_run !== 1'b1) begin
            bad++;
            $display("FAIL retry_done: pulses=%0d run=%0b required 1 1", done_cnt, cpu_run);
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        pulse_start();
        send_frame(16'd0, 0, 8'h00, 0);
        total++;
        if (done !== 1'b1 || cpu_run !== 1'b1) begin
            bad++;
            $display("FAIL zero_done: done=%0b run=%0b required 1 1", done, cpu_run);
        end
        idle(2);
        check_writes("zero", 0);
    endtask

    task automatic test_too_long();
        clear_log();
        pulse_start();
        send(8'h04, 0);
        send(8'h01, 0);
        total++;
        if (error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || cpu_run !== 1'b0) begin
            bad++;
            $display("FAIL too_long: err=%0b rdy=%0b busy=%0b run=%0b required 1 0 0 0", error, in_ready, busy, cpu_run);
        end
        in_data = 8'h55;
        in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            total++;
            if (in_ready !== 1'b0 || error !== 1'b1) begin
                bad++;
                $display("FAIL too_long_hold: rdy=%0b err=%0b required 0 1", in_ready, error);
            end
        end
        in_valid = 1'b0;
        check_writes("too_long", 0);
    endtask

    task automatic test_gaps_and_start();
        img[0] = 16'h1234; img[1] = 16'hABCD;
        clear_log();
        pulse_start();
        send(8'h00, $urandom_range(0, 5));
        send(8'h02, $urandom_range(0, 5));
        send(img[0][15:8], $urandom_range(0, 5));
        pulse_start();
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_ignored: busy=%0b rdy=%0b required 1 1", busy, in_ready);
        end
        send(img[0][7:0], $urandom_range(0, 5));
        send(img[1][15:8], $urandom_range(0, 5));
        send(img[1][7:0], $urandom_range(0, 5));
        send(8'h40, $urandom_range(0, 5));
        total++;
        if (done !== 1'b1 || cpu_run !== 1'b1) begin
            bad++;
            $display("FAIL gaps_done: done=%0b run=%0b required 1 1", done, cpu_run);
        end
        idle(2);
        check_writes("gaps", 2);
    endtask

    task automatic test_reset_mid_load();
        img[0] = 16'h1111; img[1] = 16'h2222;
        clear_log();
        pulse_start();
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'h11, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        in_data = 8'h22;
        in_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({in_ready, mem_we, mem_waddr, mem_wdata, cpu_run, busy, done, error} !== 38'd0) begin
            bad++;
            $display("FAIL mid_reset: rdy=%0b we=%0b addr=%h data=%h run=%0b busy=%0b done=%0b err=%0b required all 0",
                     in_ready, mem_we, mem_waddr, mem_wdata, cpu_run, busy, done, error);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        idle(1);
        check_writes("mid_reset", 1);
        img[0] = 16'hBEEF;
        clear_log();
        pulse_start();
        send_frame(16'd1, 1, 8'h51, 0);
        idle(2);
        check_writes("after_reset", 1);
        total++;
        if (done_cnt != 1 || cpu_run !== 1'b1) begin
            bad++;
            $display("FAIL after_reset_done: pulses=%0d run=%0b required 1 1", done_cnt, cpu_run);
        end
    endtask

    initial begin
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_zero_len();
        test_too_long();
        test_gaps_and_start();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the CPU's instruction memory. It accepts a framed byte stream over a valid/ready handshake, typically from a UART receiver. It assembles big-endian 16-bit instruction words and writes them sequentially into the instruction memory write port (`waddr`/`data_in`/`we`). It holds the CPU in reset until the image has loaded and its checksum has verified.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width. Capacity is 2**ADDR_W words.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- `in_data`  input  8  stream byte.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  loader accepts a byte this cycle. A byte transfers when `in_valid && in_ready`.
- `mem_waddr`  output  16  instruction-memory write address, zero-extended from ADDR_W bits.
- `mem_wdata`  output  16  instruction word to write.
- `mem_we`  output  1  write strobe, one cycle per word.
- `cpu_run`  output  1  high means the CPU may run. Drives the CPU's reset release.
- `busy`  output  1  load in progress (any state other than IDLE/DONE/ERROR).
- `done`  output  1  one-cycle pulse when a load completes with a good checksum.
- `error`  output  1  level; high while in ERROR.

## Operation
- Frame format:
  - LEN_HI, LEN_LO: word count N, 16-bit, high byte first.
  - N words, each sent as a high byte then a low byte.
  - One checksum byte CK, equal to the XOR of all 2N payload bytes. The length bytes are excluded from CK.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- Transitions:
  - IDLE, DONE or ERROR + `start` → LEN_HI. On entry: word counter, byte XOR accumulator and `cpu_run` are cleared.
  - LEN_HI + transfer → LEN_LO.
  - LEN_LO + transfer, by value of N:
    - N > 2**ADDR_W → ERROR.
    - N == 0 → CHECK.
    - otherwise → DATA_HI.
  - DATA_HI + transfer → DATA_LO. The high byte is latched.
  - DATA_LO + transfer → issue a write of {hi, lo} at the current word index and increment the index.
    - If index+1 == N → CHECK.
    - otherwise → DATA_HI.
  - CHECK + transfer:
    - byte == accumulator → DONE; `cpu_run` is set and `done` pulses.
    - otherwise → ERROR.
  - DONE and ERROR are sticky until the next `start`.
- `start` in LEN_HI through CHECK is ignored; a load cannot be aborted except by `rst`.
- `in_ready` = 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK. It is a registered-state decode with no combinational dependence on `in_valid`.
- The accumulator XORs every payload byte at transfer time.
- Word index is ADDR_W+1 bits wide, so N == 2**ADDR_W is legal. The last address written is 2**ADDR_W−1.
- `cpu_run` stays low during and after a failed load.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0.
  - `cpu_run`=0, `busy`=0, `done`=0, `error`=0.
- Write latency: the DATA_LO transfer at edge k produces `mem_we`=1 with the matching `mem_waddr`/`mem_wdata` during cycle k+1. All three are registered.
  - `mem_waddr`/`mem_wdata` hold their last values when `mem_we`=0.
- Maximum rate: one byte per cycle, hence one write per two cycles. Back-to-back transfers have no bubbles.
- `in_valid` low stalls any state indefinitely with no timeout.
- `cpu_run` and the `done` pulse appear in the cycle after the CHECK transfer.
- `start` coincident with a transfer in DONE/ERROR: there is no transfer, because `in_ready`=0. `start` is taken.
- `rst` asserted mid-load takes effect immediately and asynchronously:
  - all outputs return to reset values and any pending `mem_we` is dropped.
  - memory contents already written are not cleared.

## Structure
- Shared package `loader_pkg`:
  - `loader_state_t` enum.
  - `LEN_BYTES`=2 and `CK_BYTES`=1.
- Single module with no sub-modules.
  - The byte-to-word assembler is a latch register plus the FSM, and is not worth splitting out.
- At the top level:
  - `mem_*` is muxed onto the instruction memory's write port.
  - `rst && cpu_run` forms the controller/datapath reset.

## Test plan
- Load N=3, words 0x1234, 0xABCD, 0x00FF, CK=0x12^0x34^0xAB^0xCD^0x00^0xFF:
  - three `mem_we` pulses at addr 0,1,2 with those data.
  - `done` pulses; `cpu_run`=1.
- Same frame with CK xor 0x01:
  - all three words still written.
  - state ERROR, `error`=1, `cpu_run`=0.
  - a following `start` plus a good frame → `done`, `cpu_run`=1.
- N=0, CK=0x00 → no `mem_we`; `done` and `cpu_run`=1 one cycle after the CK transfer.
- N=0x0401 with ADDR_W=10 → ERROR right after LEN_LO, with no `in_ready` afterwards.
- N=2 with random `in_valid` gaps (0–5 cycles) and a `start` pulse mid-load:
  - writes are identical to the gap-free case.
  - `start` is ignored.
- `rst` low during the DATA_LO of word 1:
  - outputs reset within the same cycle, with no write for word 1.
  - the next load writes from address 0.
